// File: rtl/psr_pkg.sv
// Shared types for the parameterised shift register: operation codes and FSM states.
package psr_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_CLEAR = 3'b001,
        OP_LOAD  = 3'b010,
        OP_INC   = 3'b011,
        OP_SHL   = 3'b100,
        OP_SHR   = 3'b101,
        OP_ROL   = 3'b110,
        OP_ROR   = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/psr_if.sv
// Operation request / result bundle between a requester (master) and the shift register (slave).
interface psr_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic [WIDTH-1:0]   data_in;
    logic [2:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic               op_valid;
    logic               op_ready;
    logic [WIDTH-1:0]   data_out;
    logic               done;

    modport master (
        output data_in, op, shamt, op_valid,
        input  op_ready, data_out, done
    );

    modport slave (
        input  data_in, op, shamt, op_valid,
        output op_ready, data_out, done
    );
endinterface

// File: rtl/psr_step_unit.sv
// Single-bit-position step for SHL/SHR/ROL/ROR; other op codes pass data through.
module psr_step_unit
    import psr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  op_e              op,
    output logic [WIDTH-1:0] result
);

    // One-position shift or rotate of the current register value
    always_comb begin
        result = data;
        case (op)
            OP_SHL:  result = {data[WIDTH-2:0], 1'b0};
            OP_SHR:  result = {1'b0, data[WIDTH-1:1]};
            OP_ROL:  result = {data[WIDTH-2:0], data[WIDTH-1]};
            OP_ROR:  result = {data[0], data[WIDTH-1:1]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/param_shift_register.sv
// Parameterised shift/rotate register with a multi-cycle step FSM.
// Optional parity output enabled by defining PSR_PARITY_EN.
module param_shift_register
    import psr_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst,
    psr_if.slave       bus
`ifdef PSR_PARITY_EN
    ,
    output logic       parity_out
`endif
);

    state_e             state_r, state_next_s;
    logic [SHAMT_W-1:0] remain_r, remain_next_s;
    logic [WIDTH-1:0]   data_r, data_next_s;
    logic               done_r, done_next_s;
    op_e                run_op_r, run_op_next_s;
    op_e                step_op_s;
    op_e                req_op_s;
    logic [WIDTH-1:0]   step_result_s;

    assign req_op_s     = op_e'(bus.op);
    assign bus.op_ready = (state_r == ST_IDLE);
    assign bus.data_out = data_r;
    assign bus.done     = done_r;

`ifdef PSR_PARITY_EN
    function automatic logic calc_parity(input logic [WIDTH-1:0] value);
        return ^value;
    endfunction

    assign parity_out = calc_parity(data_r);
`endif

    psr_step_unit #(.WIDTH(WIDTH)) u_step (
        .data   (data_r),
        .op     (step_op_s),
        .result (step_result_s)
    );

    // Next-state, next-data and completion decode
    always_comb begin
        state_next_s  = state_r;
        remain_next_s = remain_r;
        data_next_s   = data_r;
        done_next_s   = 1'b0;
        run_op_next_s = run_op_r;
        step_op_s     = run_op_r;
        case (state_r)
            ST_IDLE: begin
                step_op_s = req_op_s;
                if (bus.op_valid) begin
                    case (req_op_s)
                        OP_NOP: begin
                            done_next_s = 1'b1;
                        end
                        OP_CLEAR: begin
                            data_next_s = {WIDTH{1'b0}};
                            done_next_s = 1'b1;
                        end
                        OP_LOAD: begin
                            data_next_s = bus.data_in;
                            done_next_s = 1'b1;
                        end
                        OP_INC: begin
                            data_next_s = data_r + {{(WIDTH-1){1'b0}}, 1'b1};
                            done_next_s = 1'b1;
                        end
                        default: begin
                            // Shift family: first step lands on the acceptance edge
                            if (bus.shamt == {SHAMT_W{1'b0}}) begin
                                done_next_s = 1'b1;
                            end else if (bus.shamt == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                                data_next_s = step_result_s;
                                done_next_s = 1'b1;
                            end else begin
                                data_next_s   = step_result_s;
                                state_next_s  = ST_RUN;
                                remain_next_s = bus.shamt - {{(SHAMT_W-1){1'b0}}, 1'b1};
                                run_op_next_s = req_op_s;
                            end
                        end
                    endcase
                end else begin
                    done_next_s = 1'b0;
                end
            end
            ST_RUN: begin
                data_next_s = step_result_s;
                if (remain_r == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                    state_next_s  = ST_IDLE;
                    remain_next_s = {SHAMT_W{1'b0}};
                    done_next_s   = 1'b1;
                end else begin
                    remain_next_s = remain_r - {{(SHAMT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_next_s  = ST_IDLE;
                remain_next_s = {SHAMT_W{1'b0}};
            end
        endcase
    end

    // State, counter, data and done registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            remain_r <= {SHAMT_W{1'b0}};
            data_r   <= {WIDTH{1'b0}};
            done_r   <= 1'b0;
            run_op_r <= OP_NOP;
        end else begin
            state_r  <= state_next_s;
            remain_r <= remain_next_s;
            data_r   <= data_next_s;
            done_r   <= done_next_s;
            run_op_r <= run_op_next_s;
        end
    end

endmodule

// File: tb/tb_param_shift_register.sv
// Directed self-checking bench for param_shift_register (WIDTH=8).
module tb_param_shift_register;
    import psr_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   extra_done;
`ifdef PSR_PARITY_EN
    logic parity;
`endif

    psr_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

    param_shift_register #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef PSR_PARITY_EN
        ,
        .parity_out (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic [2:0] op, input logic [7:0] din, input logic [2:0] sh);
        bus.op       = op;
        bus.data_in  = din;
        bus.shamt    = sh;
        bus.op_valid = 1'b1;
    endtask

    // Present one op for a single edge, then drop op_valid
    task automatic pulse_op(input logic [2:0] op, input logic [7:0] din, input logic [2:0] sh);
        set_op(op, din, sh);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
    endtask

    task automatic idle_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.op       = 3'b000;
        bus.data_in  = 8'h00;
        bus.shamt    = 3'd0;
        bus.op_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_data", bus.data_out, 8'h00);
        check_eq("rst_done", bus.done, 1'b0);
        check_eq("rst_ready", bus.op_ready, 1'b1);

        // LOAD 0xA5
        pulse_op(3'b010, 8'hA5, 3'd0);
        check_eq("load_data", bus.data_out, 8'hA5);
        check_eq("load_done", bus.done, 1'b1);
`ifdef PSR_PARITY_EN
        check_eq("load_parity", parity, 1'b0);
`endif
        idle_edge();
        check_eq("load_done_drop", bus.done, 1'b0);

        // ROL by 3 from 0xA5: 0x4B, 0x96, 0x2D
        pulse_op(3'b110, 8'h00, 3'd3);
        check_eq("rol_s1_data", bus.data_out, 8'h4B);
        check_eq("rol_s1_ready", bus.op_ready, 1'b0);
        check_eq("rol_s1_done", bus.done, 1'b0);
        idle_edge();
        check_eq("rol_s2_data", bus.data_out, 8'h96);
        check_eq("rol_s2_ready", bus.op_ready, 1'b0);
        check_eq("rol_s2_done", bus.done, 1'b0);
        idle_edge();
        check_eq("rol_s3_data", bus.data_out, 8'h2D);
        check_eq("rol_s3_ready", bus.op_ready, 1'b1);
        check_eq("rol_s3_done", bus.done, 1'b1);
        idle_edge();
        check_eq("rol_done_drop", bus.done, 1'b0);

        // INC wraps 0xFF to 0x00
        pulse_op(3'b010, 8'hFF, 3'd0);
        pulse_op(3'b011, 8'h00, 3'd0);
        check_eq("inc_wrap_data", bus.data_out, 8'h00);
        check_eq("inc_wrap_done", bus.done, 1'b1);
`ifdef PSR_PARITY_EN
        check_eq("inc_wrap_parity", parity, 1'b0);
`endif

        // SHR with shamt 0 leaves data, still completes in one cycle
        pulse_op(3'b010, 8'h81, 3'd0);
        pulse_op(3'b101, 8'h00, 3'd0);
        check_eq("shr0_data", bus.data_out, 8'h81);
        check_eq("shr0_done", bus.done, 1'b1);
        check_eq("shr0_ready", bus.op_ready, 1'b1);

        // ROR shamt 1 then SHL shamt 1: single-cycle steps
        pulse_op(3'b111, 8'h00, 3'd1);
        check_eq("ror1_data", bus.data_out, 8'hC0);
        check_eq("ror1_ready", bus.op_ready, 1'b1);
        pulse_op(3'b100, 8'h00, 3'd1);
        check_eq("shl1_data", bus.data_out, 8'h80);
        check_eq("shl1_done", bus.done, 1'b1);

        // NOP still pulses done; CLEAR zeroes
        pulse_op(3'b000, 8'h5A, 3'd5);
        check_eq("nop_data", bus.data_out, 8'h80);
        check_eq("nop_done", bus.done, 1'b1);
        pulse_op(3'b001, 8'h5A, 3'd0);
        check_eq("clear_data", bus.data_out, 8'h00);

        // SHL 7 from 0xFF, reset after two steps aborts without done
        pulse_op(3'b010, 8'hFF, 3'd0);
        pulse_op(3'b100, 8'h00, 3'd7);
        check_eq("abort_s1_data", bus.data_out, 8'hFE);
        idle_edge();
        check_eq("abort_s2_data", bus.data_out, 8'hFC);
        check_eq("abort_s2_ready", bus.op_ready, 1'b0);
        rst = 1'b1;
        idle_edge();
        rst = 1'b0;
        check_eq("abort_data", bus.data_out, 8'h00);
        check_eq("abort_done", bus.done, 1'b0);
        check_eq("abort_ready", bus.op_ready, 1'b1);
        extra_done = 0;
        repeat (8) begin
            idle_edge();
            if (bus.done) extra_done++;
        end
        check_eq("abort_no_done", extra_done, 0);

        // LOAD held during RUN is ignored until op_ready returns
        pulse_op(3'b010, 8'h3C, 3'd0);
        pulse_op(3'b101, 8'h00, 3'd2);
        check_eq("hold_s1_data", bus.data_out, 8'h1E);
        set_op(3'b010, 8'h00, 3'd0);
        idle_edge();
        check_eq("hold_s2_data", bus.data_out, 8'h0F);
        check_eq("hold_s2_done", bus.done, 1'b1);
        check_eq("hold_s2_ready", bus.op_ready, 1'b1);
        idle_edge();
        bus.op_valid = 1'b0;
        check_eq("hold_load_data", bus.data_out, 8'h00);
        check_eq("hold_load_done", bus.done, 1'b1);

        // Back-to-back LOAD, INC, INC, INC with op_valid held
        set_op(3'b010, 8'h01, 3'd0);
        idle_edge();
        check_eq("b2b_0_data", bus.data_out, 8'h01);
        check_eq("b2b_0_done", bus.done, 1'b1);
`ifdef PSR_PARITY_EN
        check_eq("b2b_0_parity", parity, 1'b1);
`endif
        bus.op = 3'b011;
        for (int i = 2; i <= 4; i++) begin
            idle_edge();
            check_eq("b2b_inc_data", bus.data_out, i);
            check_eq("b2b_inc_done", bus.done, 1'b1);
        end
        bus.op_valid = 1'b0;
        idle_edge();
        check_eq("b2b_done_drop", bus.done, 1'b0);
        check_eq("b2b_final_data", bus.data_out, 8'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_shift_register.md
PARAM_SHIFT_REGISTER -- requirements
Module: param_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, data register width; SHALL be >= 4.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH), width of shamt.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 data_in  input  WIDTH  load value for LOAD.
REQ-006 op  input  3  operation code (REQ-011).
REQ-007 shamt  input  SHAMT_W  step count for shift/rotate ops.
REQ-008 op_valid  input  1  op/shamt/data_in valid this cycle.
REQ-009 op_ready  output  1  block can accept an op this cycle.
REQ-010 data_out  output  WIDTH  register contents; done  output  1  one-cycle completion pulse; parity_out  output  1  present only per REQ-027.

Function
REQ-011 Op codes: 000 NOP, 001 CLEAR, 010 LOAD, 011 INC, 100 SHL, 101 SHR, 110 ROL, 111 ROR.
REQ-012 An op SHALL be accepted on a rising edge where op_valid && op_ready; otherwise op inputs are ignored.
REQ-013 FSM states IDLE and RUN; op_ready SHALL equal (state == IDLE).
REQ-014 NOP: data_out unchanged. CLEAR: data_out <= 0. LOAD: data_out <= data_in. INC: data_out <= data_out + 1 mod 2^WIDTH (all-ones wraps to 0). All take effect on the acceptance edge; the FSM stays in IDLE.
REQ-015 SHL/SHR: logical, zero fill. ROL/ROR: circular. Each SHALL move exactly one bit position per clock edge, shamt edges in total.
REQ-016 Shift op with shamt = 0: data_out unchanged, treated as single-cycle.
REQ-017 Shift op with shamt = 1: the one step occurs on the acceptance edge; the FSM stays in IDLE.
REQ-018 Shift op with shamt = s >= 2: first step on the acceptance edge; go to RUN with remaining = s-1; one step per edge; return to IDLE on the edge performing the last step.
REQ-019 Latency: the result SHALL be visible max(1,s) edges after acceptance; op_ready low for exactly max(0,s-1) cycles.
REQ-020 done SHALL be registered, high for exactly one cycle following the edge that completes an op, including NOP and shamt = 0.
REQ-021 In IDLE a new op MAY be accepted in the same cycle done is high; back-to-back single-cycle ops SHALL complete every cycle.
REQ-022 op_valid during RUN SHALL have no effect; the requester holds it until op_ready.
REQ-023 shamt >= WIDTH (non-power-of-2 WIDTH): still s single steps. SHL/SHR then yield 0; ROL/ROR yield rotation by s mod WIDTH.

Reset
REQ-024 On a rising edge with rst = 1: data_out = 0, done = 0, state = IDLE, remaining = 0; rst takes priority over any op.
REQ-025 Reset during RUN SHALL abort the op; no done pulse is issued for it; op_ready = 1 in the following cycle.
REQ-026 Before the first reset, outputs are undefined.

Configuration
REQ-027 Macro PSR_PARITY_EN defined: port parity_out = XOR-reduction of data_out, combinational from the register, always consistent with data_out.
REQ-028 PSR_PARITY_EN undefined: the parity_out port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package psr_pkg SHALL hold the op-code enum (REQ-011) and the FSM state enum.
REQ-030 One combinational sub-module psr_step_unit SHALL compute the single-step SHL/SHR/ROL/ROR result; the FSM, counter and register stay in param_shift_register.

Verification (WIDTH=8, PSR_PARITY_EN defined)
REQ-031 rst, then LOAD 0xA5 -> data_out=0xA5 after 1 edge; done high 1 cycle; parity_out=0.
REQ-032 data_out=0xA5, ROL shamt=3 -> op_ready low 2 cycles; data_out=0x2D after 3 edges; single done pulse.
REQ-033 data_out=0xFF, INC -> data_out=0x00, parity_out=0; then SHR shamt=0 on LOAD 0x81 -> data_out stays 0x81, done pulses.
REQ-034 data_out=0xFF, SHL shamt=7; rst after 2 edges -> data_out=0x00, done=0, op_ready=1 next cycle; no later done.
REQ-035 During RUN, op_valid with LOAD 0x00 held -> ignored until op_ready; then accepted; data_out=0x00 one edge later.
REQ-036 Back-to-back LOAD 0x01, INC, INC, INC with op_valid held -> data_out 0x01,0x02,0x03,0x04 on consecutive edges; done high 4 cycles.
